differentiator: RTL and testbench
=================================

Name: differentiator

Overview:
- Streaming first-difference (comb) block: y[n] = x[n] − x[n−M] on signed 22-bit Q2.20 samples; the inverse of the Integrator accumulator.
- Sits after the Integrator in the loopback datapath, or as the comb stage of a decimator.
- Integrator output fed in with M=1 reproduces the original Integrator input stream exactly (modular arithmetic).

Parameters:
- W, 22, sample width, two's complement, Q2.20.
- M, 1, differential delay in accepted samples; legal range 1..16.
- PTR_W, 4, history pointer width; must satisfy 2^PTR_W ≥ M.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous history flush; same effect as reset on datapath state.
- in_valid  in  1  In carries a sample this cycle.
- In  in  W  input sample x[n].
- out_valid  out  1  Out carries y[n] this cycle.
- Out  out  W  difference y[n].
- primed  out  1  high once M samples have been accepted since the last reset/clear.

Behaviour:
- Reset values: out_valid=0, Out=0, primed=0, all M history entries=0, write pointer=0, prime counter=0.
- History is a circular buffer of M entries, with the pointer wrapping from M−1 to 0. It is built from registers, not memory.
- Accept when in_valid=1 at a rising edge:
  - Next cycle: Out = In − hist[ptr], out_valid=1.
  - Same edge: hist[ptr] ← In, and ptr advances with wrap.
- Latency: exactly 1 clock from accepted sample to out_valid.
- When in_valid=0: out_valid=0 next cycle, Out holds its last value, history and pointer unchanged.
- No backpressure; a sample may be accepted every cycle.
- Arithmetic, default: W-bit subtraction, wrap modulo 2^W with no overflow flag. This matches Integrator wrap, so integrate-then-differentiate is exact.
- Warm-up:
  - History starts at zero, so the first M outputs equal the inputs.
  - These outputs are still flagged out_valid=1.
  - primed=0 until the M-th accept; it rises the cycle after that accept.
- Prime counter counts accepts and saturates at M.
- clear=1:
  - History, pointer and prime counter are zeroed; primed=0 next cycle.
  - out_valid/Out are unaffected except as stated below.
- clear and in_valid in the same cycle:
  - clear wins on history; the sample is differenced against zero (Out=In).
  - The sample is written into hist[0], ptr becomes 1 (wraps to 0 if M=1), and the prime counter becomes 1.
- reset mid-stream: overrides clear and in_valid, and all state returns to reset values. A sample presented during reset is discarded.
- M=1 degenerates to y[n] = x[n] − x[n−1] with a single history register.

Optional Feature:
- Macro: DIFFERENTIATOR_SAT_EN.
- Defined:
  - Compute W+1-bit difference, then clamp to +2^(W−1)−1 (22'h1FFFFF) or −2^(W−1) (22'h200000).
  - Adds output sat_flag (1 bit), high alongside out_valid when clamping occurred. sat_flag resets to 0.
- Undefined: wrap-around arithmetic as above; no sat_flag port.

Decomposition:
- Shared package integrator_pkg:
  - W and FRAC_BITS=20 constants.
  - Signed sample typedef.
  - SAT_MAX/SAT_MIN constants.
  - Also used by the Integrator.
- One natural sub-module, diff_history: circular register delay line with write pointer, prime counter and clear logic. It returns the oldest entry combinationally.
- Subtraction and saturation stay in the top module.

Test Plan:
- Reset, M=1, In 0x000100 then 0x000300 with in_valid → Out 0x000100 then 0x000200; out_valid one cycle after each; primed high after the first accept.
- Loopback: 2410-sample file through Integrator then differentiator (M=1) → output equals the original file, bit-exact after 2 cycles total latency.
- Wrap (SAT_EN undefined): x = 0x1FFFFF then 0x200000 → Out 0x000001. Same input with SAT_EN, x = 0x200000 then 0x1FFFFF → Out 0x1FFFFF, sat_flag=1.
- M=4, ramp 1,2,3,… → Out 1,2,3,4,4,4…; primed rises after the 4th accept; gaps in in_valid do not advance history.
- clear asserted with in_valid on sample 10 (value 0x000050) → Out=0x000050, primed=0, then the next three outputs equal their inputs.
- reset asserted mid-stream with in_valid=1 → out_valid=0 and Out=0 next cycle, the sample is dropped, and the first post-reset output equals its input.

Source files
------------

// File: rtl/integrator_pkg.sv
// integrator_pkg: shared Q2.20 sample width, sample type and saturation limits for the integrator/differentiator pair.
package integrator_pkg;
  localparam int W = 22;
  localparam int FRAC_BITS = 20;
  typedef logic signed [W-1:0] sample_t;
  localparam sample_t SAT_MAX = sample_t'({1'b0, {(W-1){1'b1}}});
  localparam sample_t SAT_MIN = sample_t'({1'b1, {(W-1){1'b0}}});
endpackage

// File: rtl/diff_history.sv
// diff_history: M-entry circular register delay line with write pointer, prime counter and synchronous flush.
module diff_history #(
  parameter int W = 22,
  parameter int M = 1,
  parameter int PTR_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] oldest,
  output logic         primed
);
  localparam int CW = PTR_W + 1;
  logic [W-1:0] hist_q [M];
  logic [W-1:0] hist_d [M];
  logic [PTR_W-1:0] ptr_q, ptr_d, widx;
  logic [CW-1:0] cnt_q, cnt_d, cnt_base;
  // A flush in the same cycle as a write makes that write land on a fresh, zeroed line.
  always_comb begin
    widx = clear ? '0 : ptr_q;
    oldest = clear ? '0 : hist_q[widx];
    for (int i = 0; i < M; i++)
      hist_d[i] = (wr_en && widx == PTR_W'(i)) ? wr_data : (clear ? '0 : hist_q[i]);
    ptr_d = wr_en ? ((widx == PTR_W'(M-1)) ? '0 : widx + PTR_W'(1)) : widx;
    cnt_base = clear ? '0 : cnt_q;
    cnt_d = (wr_en && cnt_base != CW'(M)) ? cnt_base + CW'(1) : cnt_base;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++) hist_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < M; i++) hist_q[i] <= hist_d[i];
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign primed = cnt_q == CW'(M);
endmodule

// File: rtl/differentiator.sv
// differentiator: streaming comb y[n] = x[n] - x[n-M], modulo 2^W by default.
// Define DIFFERENTIATOR_SAT_EN to clamp to the Q2.20 range instead and expose sat_flag.
module differentiator #(
  parameter int W = integrator_pkg::W,
  parameter int M = 1,
  parameter int PTR_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] In,
  output logic         out_valid,
  output logic [W-1:0] Out,
`ifdef DIFFERENTIATOR_SAT_EN
  output logic         sat_flag,
`endif
  output logic         primed
);
  import integrator_pkg::*;
  logic [W-1:0] oldest, diff;
  logic ovf;
  logic out_valid_q, sat_q;
  logic [W-1:0] out_q;
  diff_history #(.W(W), .M(M), .PTR_W(PTR_W)) u_hist (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(in_valid),
    .wr_data(In), .oldest(oldest), .primed(primed)
  );
`ifdef DIFFERENTIATOR_SAT_EN
  logic [W:0] ext;
  always_comb begin
    ext = {In[W-1], In} - {oldest[W-1], oldest};
    ovf = ext[W] ^ ext[W-1];
    diff = ovf ? (ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : ext[W-1:0];
  end
  assign sat_flag = sat_q;
`else
  assign diff = In - oldest;
  assign ovf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) out_q <= diff;
      sat_q <= in_valid & ovf;
    end
  end
  assign out_valid = out_valid_q;
  assign Out = out_q;
endmodule

// File: tb/tb_differentiator.sv
// tb_differentiator: directed vector table over M=1 and M=4 instances plus reset, saturation and loopback sequences.
module tb_differentiator;
  localparam int W = 22;
  logic clk = 1'b0, reset = 1'b1, clear = 1'b0, in_valid = 1'b0;
  logic [W-1:0] In = '0;
  logic ov1, ov4, pr1, pr4;
  logic [W-1:0] out1, out4;
  int checks = 0, failures = 0;
`ifdef DIFFERENTIATOR_SAT_EN
  logic sf1, sf4;
  localparam logic [W-1:0] WRAP1 = 22'h200000, WRAP4 = 22'h200000;
`else
  localparam logic [W-1:0] WRAP1 = 22'h000001, WRAP4 = 22'h1FFF90;
`endif

  always #5 clk = ~clk;

  differentiator #(.W(W), .M(1), .PTR_W(4)) dut1 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .In(In),
    .out_valid(ov1), .Out(out1),
`ifdef DIFFERENTIATOR_SAT_EN
    .sat_flag(sf1),
`endif
    .primed(pr1));
  differentiator #(.W(W), .M(4), .PTR_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .In(In),
    .out_valid(ov4), .Out(out4),
`ifdef DIFFERENTIATOR_SAT_EN
    .sat_flag(sf4),
`endif
    .primed(pr4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic [W-1:0] x);
    reset = r; clear = c; in_valid = v; In = x;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic clr, vld;
    logic [W-1:0] x;
    logic ov1;
    logic [W-1:0] o1;
    logic pr1, ov4;
    logic [W-1:0] o4;
    logic pr4;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [W-1:0] acc, dx;
    tbl[0]  = '{0,1,22'h000100, 1,22'h000100,1, 1,22'h000100,0};
    tbl[1]  = '{0,1,22'h000300, 1,22'h000200,1, 1,22'h000300,0};
    tbl[2]  = '{0,0,22'h000999, 0,22'h000200,1, 0,22'h000300,0};
    tbl[3]  = '{1,0,22'h000000, 0,22'h000200,0, 0,22'h000300,0};
    tbl[4]  = '{0,1,22'h000001, 1,22'h000001,1, 1,22'h000001,0};
    tbl[5]  = '{0,1,22'h000002, 1,22'h000001,1, 1,22'h000002,0};
    tbl[6]  = '{0,0,22'h000007, 0,22'h000001,1, 0,22'h000002,0};
    tbl[7]  = '{0,1,22'h000003, 1,22'h000001,1, 1,22'h000003,0};
    tbl[8]  = '{0,1,22'h000004, 1,22'h000001,1, 1,22'h000004,1};
    tbl[9]  = '{0,1,22'h000005, 1,22'h000001,1, 1,22'h000004,1};
    tbl[10] = '{0,1,22'h000006, 1,22'h000001,1, 1,22'h000004,1};
    tbl[11] = '{0,0,22'h000000, 0,22'h000001,1, 0,22'h000004,1};
    tbl[12] = '{0,1,22'h000007, 1,22'h000001,1, 1,22'h000004,1};
    tbl[13] = '{1,1,22'h000050, 1,22'h000050,1, 1,22'h000050,0};
    tbl[14] = '{0,1,22'h000060, 1,22'h000010,1, 1,22'h000060,0};
    tbl[15] = '{0,1,22'h000070, 1,22'h000010,1, 1,22'h000070,0};
    tbl[16] = '{0,1,22'h000080, 1,22'h000010,1, 1,22'h000080,1};
    tbl[17] = '{0,1,22'h000090, 1,22'h000010,1, 1,22'h000040,1};
    tbl[18] = '{0,1,22'h1FFFFF, 1,22'h1FFF6F,1, 1,22'h1FFF9F,1};
    tbl[19] = '{0,1,22'h200000, 1,WRAP1,     1, 1,WRAP4,     1};

    step(1, 0, 0, '0);
    step(1, 0, 1, 22'h000777);
    check("rst_ov1", 32'(ov1), 32'd0);
    check("rst_out1", 32'(out1), 32'd0);
    check("rst_pr1", 32'(pr1), 32'd0);
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_pr4", 32'(pr4), 32'd0);

    for (int i = 0; i < 20; i++) begin
      step(0, tbl[i].clr, tbl[i].vld, tbl[i].x);
      check($sformatf("v%0d_ov1", i), 32'(ov1), 32'(tbl[i].ov1));
      check($sformatf("v%0d_out1", i), 32'(out1), 32'(tbl[i].o1));
      check($sformatf("v%0d_pr1", i), 32'(pr1), 32'(tbl[i].pr1));
      check($sformatf("v%0d_ov4", i), 32'(ov4), 32'(tbl[i].ov4));
      check($sformatf("v%0d_out4", i), 32'(out4), 32'(tbl[i].o4));
      check($sformatf("v%0d_pr4", i), 32'(pr4), 32'(tbl[i].pr4));
    end

    // Reset in the middle of a stream drops the sample presented with it.
    step(0, 0, 1, 22'h000010);
    step(1, 0, 1, 22'h000123);
    check("mrst_ov1", 32'(ov1), 32'd0);
    check("mrst_out1", 32'(out1), 32'd0);
    check("mrst_ov4", 32'(ov4), 32'd0);
    check("mrst_out4", 32'(out4), 32'd0);
    check("mrst_pr4", 32'(pr4), 32'd0);
    step(0, 0, 1, 22'h000055);
    check("post_out1", 32'(out1), 32'h55);
    check("post_out4", 32'(out4), 32'h55);
    check("post_pr1", 32'(pr1), 32'd1);
    check("post_pr4", 32'(pr4), 32'd0);

    step(0, 0, 1, 22'h200000);
    step(0, 0, 1, 22'h1FFFFF);
`ifdef DIFFERENTIATOR_SAT_EN
    check("sat_out1", 32'(out1), 32'h1FFFFF);
    check("sat_flag1", 32'(sf1), 32'd1);
`else
    check("wrap_out1", 32'(out1), 32'h3FFFFF);
`endif

    // Loopback: accumulate a stream and expect the M=1 comb to recover it.
    step(0, 1, 0, '0);
    acc = '0;
    for (int n = 0; n < 40; n++) begin
      dx = W'($urandom_range(0, 32'h1FFF)) - W'(32'h1000);
      acc = acc + dx;
      step(0, 0, 1, acc);
      check($sformatf("loop%0d", n), 32'(out1), 32'(dx));
    end
    step(0, 0, 0, '0);
    check("loop_idle_ov1", 32'(ov1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
